// File: rtl/dm_pkg.sv
// Shared types for the data-memory load/store unit: access size, FSM state,
// and the byte-count helper.
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_ACCESS = 2'b10,
    S_RESP   = 2'b11
  } state_e;

  // The reserved size is always rejected; it reports 4 so the range check stays well-defined.
  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dm_byte_align.sv
// Combinational big-endian lane steering: load extraction with sign/zero
// extension, and store byte-lane data plus enables. Lane k maps to mem[a+k].
module dm_byte_align
  import dm_pkg::*;
(
  input  size_e             size,
  input  logic              unsigned_ld,
  input  logic [3:0][7:0]   rd_bytes,
  input  logic [31:0]       wdata,
  output logic [31:0]       ld_data,
  output logic [3:0][7:0]   wr_bytes,
  output logic [3:0]        wr_en
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = rd_bytes[0];
  assign half_s = {rd_bytes[0], rd_bytes[1]};

  always_comb begin
    ld_data = '0;
    case (size)
      SZ_BYTE: ld_data = unsigned_ld ? {24'd0, rd_bytes[0]} : 32'(byte_s);
      SZ_HALF: ld_data = unsigned_ld ? {16'd0, rd_bytes[0], rd_bytes[1]} : 32'(half_s);
      SZ_WORD: ld_data = {rd_bytes[0], rd_bytes[1], rd_bytes[2], rd_bytes[3]};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    wr_bytes = '0;
    wr_en    = 4'b0000;
    case (size)
      SZ_BYTE: begin
        wr_bytes[0] = wdata[7:0];
        wr_en       = 4'b0001;
      end
      SZ_HALF: begin
        wr_bytes[0] = wdata[15:8];
        wr_bytes[1] = wdata[7:0];
        wr_en       = 4'b0011;
      end
      SZ_WORD: begin
        wr_bytes[0] = wdata[31:24];
        wr_bytes[1] = wdata[23:16];
        wr_bytes[2] = wdata[15:8];
        wr_bytes[3] = wdata[7:0];
        wr_en       = 4'b1111;
      end
      default: begin
        wr_bytes = '0;
        wr_en    = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Byte-addressed big-endian data memory with a valid/ready load/store front end.
// Define DM_MISALIGN_CHECK_EN to reject misaligned half/word accesses instead of masking.
module dm_lsu
  import dm_pkg::*;
#(
  parameter int MEM_BYTES   = 128,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = $clog2(MEM_BYTES);

  state_e state, state_nxt;
  logic [3:0] cnt;

  logic              write_p0;
  logic              unsigned_p0;
  size_e             size_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [31:0]       wdata_p0;

  logic [31:0] rdata_p1;
  logic        err_p1;

  logic [7:0] DataMem [0:MEM_BYTES-1];

  logic            accept;
  logic [ADDR_W:0] last_addr;
  logic            range_err;
  logic            mis_err;
  logic            err;
  logic [IW-1:0]   idx;
  logic [3:0][7:0] rd_bytes;
  logic [3:0][7:0] wr_bytes;
  logic [3:0]      wr_en;
  logic [31:0]     ld_data;

  assign accept = (state == S_IDLE) && req_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt == 4'd1) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= 4'd0;
    else if (accept)          cnt <= 4'(WAIT_STATES);
    else if (state == S_WAIT) cnt <= cnt - 4'd1;
  end

  // Request capture (p0): fields are held stable until the response ends.
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0    <= req_write;
      unsigned_p0 <= req_unsigned;
      size_p0     <= size_e'(req_size);
      addr_p0     <= req_addr;
      wdata_p0    <= req_wdata;
    end
  end

  // Range check on the raw address, one bit wider so the end address cannot wrap.
  assign last_addr = {1'b0, addr_p0} + (ADDR_W+1)'(size_bytes(size_p0)) - (ADDR_W+1)'(1);
  assign range_err = last_addr >= (ADDR_W+1)'(MEM_BYTES);

`ifdef DM_MISALIGN_CHECK_EN
  assign mis_err = ((size_p0 == SZ_HALF) && addr_p0[0]) ||
                   ((size_p0 == SZ_WORD) && (addr_p0[1:0] != 2'b00));
  assign idx     = addr_p0[IW-1:0];
`else
  assign mis_err = 1'b0;
  always_comb begin
    idx = addr_p0[IW-1:0];
    case (size_p0)
      SZ_HALF: idx = {addr_p0[IW-1:1], 1'b0};
      SZ_WORD: idx = {addr_p0[IW-1:2], 2'b00};
      default: idx = addr_p0[IW-1:0];
    endcase
  end
`endif

  assign err = (size_p0 == SZ_RSVD) || range_err || mis_err;

  // Index wraps modulo MEM_BYTES; lanes past the access size are never used.
  always_comb begin
    rd_bytes = '0;
    for (int k = 0; k < 4; k++) rd_bytes[k] = DataMem[idx + IW'(k)];
  end

  dm_byte_align u_align (
    .size        (size_p0),
    .unsigned_ld (unsigned_p0),
    .rd_bytes    (rd_bytes),
    .wdata       (wdata_p0),
    .ld_data     (ld_data),
    .wr_bytes    (wr_bytes),
    .wr_en       (wr_en)
  );

  // Access stage: the write is suppressed if reset lands on this edge.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_ACCESS) && write_p0 && !err) begin
      for (int k = 0; k < 4; k++)
        if (wr_en[k]) DataMem[idx + IW'(k)] <= wr_bytes[k];
    end
  end

  // Response capture (p1)
  always_ff @(posedge clk) begin
    if (state == S_ACCESS) begin
      rdata_p1 <= (err || write_p0) ? 32'd0 : ld_data;
      err_p1   <= err;
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rsp_valid ? rdata_p1 : 32'd0;
  assign rsp_err   = rsp_valid && err_p1;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed plus randomized bench for dm_lsu (WAIT_STATES=3) against a
// byte-array reference model; follows DM_MISALIGN_CHECK_EN when defined.
module tb_dm_lsu;

  localparam int MB = 128;
  localparam int WS = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;
  logic [7:0] mem_m [MB];

  always #5 clk = ~clk;

  dm_lsu #(.MEM_BYTES(MB), .ADDR_W(32), .WAIT_STATES(WS)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
    longint last;
    if (sz == 2'b11) return 1'b1;
    last = longint'(a) + nbytes(sz) - 1;
    if (last >= MB) return 1'b1;
`ifdef DM_MISALIGN_CHECK_EN
    if ((a % nbytes(sz)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int eff_addr(input logic [31:0] a, input logic [1:0] sz);
    int n = nbytes(sz);
    return int'(a) - (int'(a) % n);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int n = nbytes(sz);
    int e = eff_addr(a, sz);
    longint v = 0;
    for (int i = 0; i < n; i++) v = v * 256 + mem_m[e + i];
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int n = nbytes(sz);
    int e = eff_addr(a, sz);
    for (int i = 0; i < n; i++) mem_m[e + i] = 8'((d >> (8 * (n - 1 - i))) & 32'hFF);
  endtask

  // Called on a negedge; returns on the negedge of the first idle cycle after the response.
  task automatic txn(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                     input logic [31:0] wd, input string tag);
    logic [31:0] exp_d, got_d;
    logic exp_e, got_e, hs_bad;
    int n = 0;
    exp_e = model_err(a, sz);
    exp_d = (w || exp_e) ? 32'd0 : model_load(a, sz, u);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check({tag, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = $urandom; req_addr = $urandom;
    hs_bad = 1'b0; got_d = '0; got_e = 1'b0;
    for (int k = 1; k <= WS + 3; k++) begin
      @(negedge clk);
      if (k <= WS + 2 && req_ready) hs_bad = 1'b1;
      if (k == WS + 3 && !req_ready) hs_bad = 1'b1;
      if (rsp_valid !== (k == WS + 2)) hs_bad = 1'b1;
      if (k == WS + 2) begin got_d = rsp_rdata; got_e = rsp_err; end
    end
    check({tag, "_handshake"}, {31'd0, hs_bad}, 32'd0);
    check({tag, "_rdata"}, got_d, exp_d);
    check({tag, "_err"}, {31'd0, got_e}, {31'd0, exp_e});
    if (w && !exp_e) model_store(a, sz, wd);
  endtask

  // Store whose transaction is killed by a reset sampled at edge rst_cyc after accept.
  task automatic aborted_store(input logic [31:0] a, input logic [31:0] wd, input int rst_cyc,
                               input string tag);
    logic bad = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k < rst_cyc; k++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < WS + 4; k++) begin
      @(negedge clk);
      if (rsp_valid || !req_ready) bad = 1'b1;
    end
    check({tag, "_no_rsp"}, {31'd0, bad}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'd0, req_ready}, 32'd1);
    check("reset_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rdata", rsp_rdata, 32'd0);
    check("reset_err", {31'd0, rsp_err}, 32'd0);

    for (int i = 0; i < MB; i += 4) txn(1'b1, 2'b10, 1'b0, 32'(i), $urandom, "init");

    txn(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "t1_sw");
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "t1_lw");
    txn(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, "t1_lb");
    txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, "t1_lbu");

    txn(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, "t2_sw");
    txn(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234, "t2_sh");
    txn(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "t2_lw");
    txn(1'b1, 2'b01, 1'b0, 32'h22, 32'h8001, "t2_sh2");
    txn(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, "t2_lh");
    txn(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, "t2_lhu");

    txn(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, "t3_lw_mis");
    txn(1'b1, 2'b01, 1'b0, 32'h15, 32'hA5A5, "t3_sh_mis");
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "t3_lw_chk");
    txn(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, "t3_lw_chk2");

    txn(1'b0, 2'b10, 1'b0, 32'h7E, 32'h0, "t4_lw_oor");
    txn(1'b1, 2'b00, 1'b0, 32'h80, 32'h55, "t4_sb_oor");
    txn(1'b1, 2'b00, 1'b0, 32'h7F, 32'h66, "t4_sb_last");
    txn(1'b0, 2'b00, 1'b1, 32'h7F, 32'h0, "t4_lb_last");
    txn(1'b0, 2'b11, 1'b0, 32'h04, 32'h0, "t4_rsvd");
    txn(1'b1, 2'b11, 1'b0, 32'h04, 32'h12345678, "t4_rsvd_st");
    txn(1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'h11111111, "t4_hi_addr");
    txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "t4_lw_chk");

    aborted_store(32'h40, 32'hCAFEF00D, 2, "t6_wait");
    txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, "t6_lw_wait");
    aborted_store(32'h40, 32'hCAFEF00D, WS + 1, "t6_access");
    txn(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, "t6_lw_access");

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? (32'h0100_0000 | 32'($urandom_range(0, 127)))
                                      : 32'($urandom_range(0, MB + 7));
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom, "rand");
    end
    for (int i = 0; i < MB; i += 4) txn(1'b0, 2'b10, 1'b0, 32'(i), 32'h0, "final_dump");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
